// File: rtl/board_row_streamer_if.sv
// Bus between game logic / renderer and the board row streamer.
// index != 5'h1F marks a one-cycle row write to the renderer; no backpressure.
interface board_row_streamer_if #(
    parameter int COLS   = 10,
    parameter int CELL_W = 3
);
    logic                   cell_we;
    logic [4:0]             cell_row;
    logic [3:0]             cell_col;
    logic [CELL_W-1:0]      cell_val;
    logic                   clear;
    logic                   full_refresh;
    logic                   vblank;
    logic [4:0]             index;
    logic [COLS*CELL_W-1:0] row_data;
    logic                   busy;
    logic                   fsm_state;

    modport master (
        output cell_we, cell_row, cell_col, cell_val, clear, full_refresh, vblank,
        input  index, row_data, busy, fsm_state
    );

    modport slave (
        input  cell_we, cell_row, cell_col, cell_val, clear, full_refresh, vblank,
        output index, row_data, busy, fsm_state
    );
endinterface

// File: rtl/board_row_streamer.sv
// Shadow Tetris board; streams dirty rows to the renderer during vertical blanking,
// lowest row first, one row per clock.
module board_row_streamer #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int CELL_W = 3
) (
    input logic                 clk,
    input logic                 rst,
    board_row_streamer_if.slave bus
);
    localparam int         RW       = COLS * CELL_W;
    localparam logic [4:0] IDLE_IDX = 5'h1F;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   board_q [ROWS];
    logic [ROWS-1:0] dirty_q, dirty_d;
    logic [4:0]      index_q;
    logic [RW-1:0]   row_data_q;
    logic [4:0]      low_row;
    logic            write_ok, any_dirty, emit, collide;

    assign write_ok  = bus.cell_we && (bus.cell_row < 5'(ROWS)) && (bus.cell_col < 4'(COLS));
    assign any_dirty = |dirty_q;
    assign emit      = (state_q == STREAM) && bus.vblank && any_dirty;

    always_comb begin
        low_row = 5'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (dirty_q[i]) low_row = 5'(i);
        end
    end

    // Any same-edge change to the emitted row keeps it dirty so the newer data follows.
    assign collide = bus.clear || bus.full_refresh || (write_ok && (bus.cell_row == low_row));

    always_comb begin
        dirty_d = dirty_q;
        if (emit && !collide) dirty_d[low_row] = 1'b0;
        if (write_ok) dirty_d[bus.cell_row] = 1'b1;
        if (bus.clear || bus.full_refresh) dirty_d = '1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.vblank && any_dirty) state_d = STREAM;
            STREAM:  if (!bus.vblank || !any_dirty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dirty_q    <= '1;
            index_q    <= IDLE_IDX;
            row_data_q <= '0;
        end else begin
            state_q <= state_d;
            dirty_q <= dirty_d;
            index_q <= emit ? low_row : IDLE_IDX;
            if (emit) row_data_q <= board_q[low_row];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) board_q[i] <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (bus.clear) begin
                    board_q[i] <= '0;
                end else if (write_ok && (bus.cell_row == 5'(i))) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (bus.cell_col == 4'(c)) board_q[i][c*CELL_W +: CELL_W] <= bus.cell_val;
                    end
                end
            end
        end
    end

    assign bus.index     = index_q;
    assign bus.row_data  = row_data_q;
    assign bus.busy      = any_dirty;
    assign bus.fsm_state = (state_q == STREAM);
endmodule

// File: tb/tb_board_row_streamer.sv
// Directed bench for board_row_streamer: expected row writes are queued by the
// stimulus and popped by a monitor whenever the streamer emits a row.
module tb_board_row_streamer;
    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int CELL_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    board_row_streamer_if #(.COLS(COLS), .CELL_W(CELL_W)) bus();

    board_row_streamer #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [34:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_row(input int r, input logic [29:0] d);
        exp_q.push_back({5'(r), d});
    endtask

    task automatic cell_write(input int r, input int c, input int v);
        bus.cell_we  = 1'b1;
        bus.cell_row = 5'(r);
        bus.cell_col = 4'(c);
        bus.cell_val = 3'(v);
        tick(1);
        bus.cell_we  = 1'b0;
    endtask

    task automatic run_vblank(input int n);
        bus.vblank = 1'b1;
        tick(n);
        bus.vblank = 1'b0;
    endtask

    task automatic pulse_refresh();
        bus.full_refresh = 1'b1;
        tick(1);
        bus.full_refresh = 1'b0;
    endtask

    // Monitor: every cycle with a valid index must match the next queued row.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.index !== 5'h1F) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_row: got index %0d data %h, expected no row", bus.index, bus.row_data);
            end else begin
                check("row_emit", {bus.index, bus.row_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.cell_we      = 1'b0;
        bus.cell_row     = '0;
        bus.cell_col     = '0;
        bus.cell_val     = '0;
        bus.clear        = 1'b0;
        bus.full_refresh = 1'b0;
        bus.vblank       = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("reset_index", 35'(bus.index), 35'h1F);
        check("reset_row_data", 35'(bus.row_data), 35'd0);
        check("reset_busy", 35'(bus.busy), 35'd1);
        check("reset_state", 35'(bus.fsm_state), 35'd0);

        // Initial upload of all 20 rows.
        for (int r = 0; r < ROWS; r++) push_row(r, 30'd0);
        run_vblank(25);
        tick(2);
        check("t1_busy", 35'(bus.busy), 35'd0);
        check("t1_drained", 35'(exp_q.size()), 35'd0);

        // Write held back until vblank.
        cell_write(5, 3, 6);
        tick(3);
        check("t2_busy", 35'(bus.busy), 35'd1);
        check("t2_idle_index", 35'(bus.index), 35'h1F);
        push_row(5, 30'h0000_0C00);
        run_vblank(4);
        tick(2);
        check("t2_hold_data", 35'(bus.row_data), 35'h0000_0C00);
        check("t2_busy_clear", 35'(bus.busy), 35'd0);

        // Refresh split across two blanking intervals.
        pulse_refresh();
        for (int r = 0; r <= 6; r++) push_row(r, (r == 5) ? 30'h0000_0C00 : 30'd0);
        run_vblank(8);
        check("t3_busy_mid", 35'(bus.busy), 35'd1);
        tick(3);
        check("t3_no_emit_low", 35'(bus.index), 35'h1F);
        for (int r = 7; r < ROWS; r++) push_row(r, 30'd0);
        run_vblank(16);
        tick(2);
        check("t3_busy", 35'(bus.busy), 35'd0);
        check("t3_drained", 35'(exp_q.size()), 35'd0);

        // Collision: write row 2 on the edge that emits row 2.
        pulse_refresh();
        push_row(0, 30'd0);
        push_row(1, 30'd0);
        push_row(2, 30'd0);
        push_row(2, 30'd7);
        for (int r = 3; r < ROWS; r++) push_row(r, (r == 5) ? 30'h0000_0C00 : 30'd0);
        bus.vblank = 1'b1;
        tick(3);
        cell_write(2, 0, 7);
        tick(22);
        bus.vblank = 1'b0;
        tick(2);
        check("t4_busy", 35'(bus.busy), 35'd0);
        check("t4_drained", 35'(exp_q.size()), 35'd0);

        // Out-of-range writes are ignored.
        cell_write(20, 0, 5);
        check("t5_row20_busy", 35'(bus.busy), 35'd0);
        cell_write(3, 10, 5);
        check("t5_col10_busy", 35'(bus.busy), 35'd0);
        cell_write(31, 15, 7);
        check("t5_row31_busy", 35'(bus.busy), 35'd0);
        pulse_refresh();
        for (int r = 0; r < ROWS; r++)
            push_row(r, (r == 5) ? 30'h0000_0C00 : ((r == 2) ? 30'd7 : 30'd0));
        run_vblank(22);
        tick(2);
        check("t5_drained", 35'(exp_q.size()), 35'd0);

        // Clear wins over a same-edge write.
        bus.clear = 1'b1;
        cell_write(4, 0, 3);
        bus.clear = 1'b0;
        check("t6_busy", 35'(bus.busy), 35'd1);
        for (int r = 0; r < ROWS; r++) push_row(r, 30'd0);
        run_vblank(22);
        tick(2);
        check("t6_busy_done", 35'(bus.busy), 35'd0);
        check("t6_drained", 35'(exp_q.size()), 35'd0);

        // Asynchronous reset in the middle of a stream.
        cell_write(0, 9, 5);
        pulse_refresh();
        push_row(0, 30'h2800_0000);
        bus.vblank = 1'b1;
        tick(2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_index", 35'(bus.index), 35'h1F);
        check("t7_rst_row_data", 35'(bus.row_data), 35'd0);
        check("t7_rst_busy", 35'(bus.busy), 35'd1);
        check("t7_rst_state", 35'(bus.fsm_state), 35'd0);
        bus.vblank = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(2);
        check("t7_busy_after", 35'(bus.busy), 35'd1);
        check("final_drained", 35'(exp_q.size()), 35'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
